// File: rtl/addec_bus_sequencer_if.sv
// CPU, decode-PROM and peripheral bus signals of the bus cycle sequencer.
// master is the sequencer side, slave is the CPU/PROM/peripheral side.
interface addec_bus_sequencer_if;
    logic        cpu_req;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [4:0]  prom_addr;
    logic [7:0]  prom_q;
    logic [15:0] bus_addr;
    logic [7:0]  bus_sel;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;

    modport master (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, prom_q, bus_din,
        output cpu_ack, cpu_rdata, prom_addr, bus_addr,
        output bus_sel, bus_rd, bus_wr, bus_dout
    );

    modport slave (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata, prom_q, bus_din,
        input  cpu_ack, cpu_rdata, prom_addr, bus_addr,
        input  bus_sel, bus_rd, bus_wr, bus_dout
    );
endinterface

// File: rtl/addec_bus_sequencer.sv
// Bus cycle sequencer: PROM page lookup, timed chip-selects and strobes,
// and a one-cycle ack back to the CPU, with per-region wait states.
module addec_bus_sequencer #(
    parameter int unsigned WAIT_ROM      = 1,
    parameter int unsigned WAIT_IO       = 0,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
    input logic clock,
    input logic reset_n,
    addec_bus_sequencer_if.master bus
);
    localparam int unsigned WMAX = (WAIT_ROM > WAIT_IO) ? WAIT_ROM : WAIT_IO;
    localparam int CW = (WMAX > 0) ? $clog2(WMAX + 1) : 1;
    localparam logic [CW-1:0] W_ROM = CW'(WAIT_ROM);
    localparam logic [CW-1:0] W_IO  = CW'(WAIT_IO);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_LOOKUP = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          rw_q;
    logic [15:0]   addr_q;
    logic [7:0]    wdata_q;
    logic          ack_q;
    logic [7:0]    rdata_q;
    logic [7:0]    sel_q;
    logic          rd_q;
    logic          wr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        addr_q  <= bus.cpu_addr;
                        rw_q    <= bus.cpu_rw;
                        wdata_q <= bus.cpu_wdata;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: state <= S_LOOKUP;
                S_LOOKUP: begin
                    // An all-zero decode word means no device owns the page
                    if (bus.prom_q == 8'h00) begin
                        if (rw_q) rdata_q <= UNMAPPED_DATA;
                        ack_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        sel_q <= bus.prom_q;
                        rd_q  <= rw_q;
                        wr_q  <= ~rw_q;
                        cnt   <= bus.prom_q[0] ? W_IO : W_ROM;
                        state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (rw_q) rdata_q <= bus.bus_din;
                        sel_q <= '0;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        ack_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.prom_addr = addr_q[15:11];
    assign bus.bus_addr  = addr_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_rd    = rd_q;
    assign bus.bus_wr    = wr_q;
    assign bus.bus_dout  = wdata_q;
endmodule
